// File: rtl/fetchu.sv
// Instruction fetch / program-counter stage driven by the scheduler phase strobes.
// Optional interrupt entry at write-back is enabled by defining FETCHU_IRQ_EN.
module fetchu #(
    parameter int unsigned     AW       = 16,
    parameter int unsigned     DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = 'h0000,
    parameter logic [AW-1:0]   IRQ_VEC  = 'h0002
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          phf,
    input  logic          phe,
    input  logic          phm,
    input  logic          phw,
    input  logic [DW-1:0] mem_rdata,
    input  logic [AW-1:0] dmem_addr,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          irq,
    output logic [AW-1:0] mem_addr,
    output logic          mem_fetch,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ic,
    output logic          inst_valid,
    output logic [31:0]   icnt,
    output logic          phase_err,
    output logic          irq_ack,
    output logic [AW-1:0] epc
);

    // phase     | meaning
    // PH_IDLE   | no strobe high (scheduler in reset), nothing updates
    // PH_FETCH  | capture mem_rdata into ic
    // PH_EXEC   | advance pc
    // PH_MEM    | data access on the shared bus, no state change
    // PH_WB     | retire: count, apply branch / interrupt
    // PH_ERR    | more than one strobe high, only phase_err updates
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FETCH,
        PH_EXEC,
        PH_MEM,
        PH_WB,
        PH_ERR
    } phase_t;

    phase_t     phase;
    logic [2:0] ph_count;

    always_comb begin
        ph_count = {2'b00, phf} + {2'b00, phe} + {2'b00, phm} + {2'b00, phw};
        phase    = PH_IDLE;
        if (ph_count > 3'd1)
            phase = PH_ERR;
        else if (phf)
            phase = PH_FETCH;
        else if (phe)
            phase = PH_EXEC;
        else if (phm)
            phase = PH_MEM;
        else if (phw)
            phase = PH_WB;
    end

    // The shared bus belongs to fetch only while phf is high, with no register stage.
    assign mem_addr  = phf ? pc : dmem_addr;
    assign mem_fetch = phf;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            ic         <= '0;
            inst_valid <= 1'b0;
            icnt       <= '0;
            phase_err  <= 1'b0;
        end else begin
            case (phase)
                PH_ERR: phase_err <= 1'b1;
                PH_FETCH: begin
                    ic         <= mem_rdata;
                    inst_valid <= 1'b1;
                end
                PH_EXEC: pc <= pc + AW'(1);
                PH_WB: begin
                    icnt <= icnt + 32'd1;
`ifdef FETCHU_IRQ_EN
                    if (irq)
                        pc <= IRQ_VEC;
                    else if (branch_taken)
                        pc <= branch_target;
`else
                    if (branch_taken)
                        pc <= branch_target;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef FETCHU_IRQ_EN
    // Interrupt entry wins over a branch; the branch destination becomes the return PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_ack <= 1'b0;
            epc     <= '0;
        end else begin
            irq_ack <= 1'b0;
            if (phase == PH_WB && irq) begin
                irq_ack <= 1'b1;
                epc     <= branch_taken ? branch_target : pc;
            end
        end
    end
`else
    logic          unused_irq;
    logic [AW-1:0] unused_irq_vec;
    assign unused_irq     = irq;
    assign unused_irq_vec = IRQ_VEC;
    assign irq_ack        = 1'b0;
    assign epc            = '0;
`endif

endmodule

// File: tb/tb_fetchu.sv
// Directed bench for fetchu: vector table for the normal phase sequence plus
// hand-written sequences for phase error, mid-op reset, PC wrap and interrupt entry.
module tb_fetchu;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          phf, phe, phm, phw;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] dmem_addr;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          irq;

    logic [AW-1:0] mem_addr, pc, epc;
    logic          mem_fetch, inst_valid, phase_err, irq_ack;
    logic [DW-1:0] ic;
    logic [31:0]   icnt;

    logic [AW-1:0] w_mem_addr, w_pc, w_epc;
    logic          w_mem_fetch, w_inst_valid, w_phase_err, w_irq_ack;
    logic [DW-1:0] w_ic;
    logic [31:0]   w_icnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetchu #(.AW(AW), .DW(DW), .RESET_PC(16'h0000), .IRQ_VEC(16'h0002)) u_dut (
        .clk(clk), .reset(reset), .phf(phf), .phe(phe), .phm(phm), .phw(phw),
        .mem_rdata(mem_rdata), .dmem_addr(dmem_addr), .branch_taken(branch_taken),
        .branch_target(branch_target), .irq(irq), .mem_addr(mem_addr),
        .mem_fetch(mem_fetch), .pc(pc), .ic(ic), .inst_valid(inst_valid),
        .icnt(icnt), .phase_err(phase_err), .irq_ack(irq_ack), .epc(epc)
    );

    fetchu #(.AW(AW), .DW(DW), .RESET_PC(16'hFFFF), .IRQ_VEC(16'h0002)) u_wrap (
        .clk(clk), .reset(reset), .phf(phf), .phe(phe), .phm(phm), .phw(phw),
        .mem_rdata(mem_rdata), .dmem_addr(dmem_addr), .branch_taken(branch_taken),
        .branch_target(branch_target), .irq(irq), .mem_addr(w_mem_addr),
        .mem_fetch(w_mem_fetch), .pc(w_pc), .ic(w_ic), .inst_valid(w_inst_valid),
        .icnt(w_icnt), .phase_err(w_phase_err), .irq_ack(w_irq_ack), .epc(w_epc)
    );

    typedef struct {
        logic [3:0]  ph;      // {phf, phe, phm, phw}
        logic        bt;
        logic [15:0] tgt;
        logic [31:0] rdata;
        logic [15:0] dmem;
        logic [15:0] e_addr;  // combinational mem_addr during the vector
        logic        e_fetch;
        logic [15:0] e_pc;    // registered values after the posedge
        logic [31:0] e_ic;
        logic        e_valid;
        logic [31:0] e_icnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, like the scheduler does.
    task automatic drive(input logic [3:0] ph, input logic bt, input logic [15:0] tgt,
                         input logic [31:0] rdata, input logic [15:0] dmem, input logic irq_i);
        @(negedge clk);
        {phf, phe, phm, phw} = ph;
        branch_taken  = bt;
        branch_target = tgt;
        mem_rdata     = rdata;
        dmem_addr     = dmem;
        irq           = irq_i;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 16'h0000, 32'h0,        16'h0011, 16'h0011, 1'b0, 16'h0000, 32'h0,        1'b0, 32'd0};
        vecs[1]  = '{4'b1000, 1'b0, 16'h0000, 32'hDEAD0000, 16'h0011, 16'h0000, 1'b1, 16'h0000, 32'hDEAD0000, 1'b1, 32'd0};
        vecs[2]  = '{4'b1000, 1'b0, 16'h0000, 32'hA5A50001, 16'h0011, 16'h0000, 1'b1, 16'h0000, 32'hA5A50001, 1'b1, 32'd0};
        vecs[3]  = '{4'b0100, 1'b1, 16'h0077, 32'h0,        16'h0022, 16'h0022, 1'b0, 16'h0001, 32'hA5A50001, 1'b1, 32'd0};
        vecs[4]  = '{4'b0010, 1'b0, 16'h0000, 32'h0,        16'h1234, 16'h1234, 1'b0, 16'h0001, 32'hA5A50001, 1'b1, 32'd0};
        vecs[5]  = '{4'b0001, 1'b0, 16'h0055, 32'h0,        16'h0000, 16'h0000, 1'b0, 16'h0001, 32'hA5A50001, 1'b1, 32'd1};
        vecs[6]  = '{4'b1000, 1'b0, 16'h0000, 32'h11110000, 16'h0033, 16'h0001, 1'b1, 16'h0001, 32'h11110000, 1'b1, 32'd1};
        vecs[7]  = '{4'b0100, 1'b0, 16'h0000, 32'h0,        16'h0033, 16'h0033, 1'b0, 16'h0002, 32'h11110000, 1'b1, 32'd1};
        vecs[8]  = '{4'b0010, 1'b0, 16'h0000, 32'h0,        16'h0044, 16'h0044, 1'b0, 16'h0002, 32'h11110000, 1'b1, 32'd1};
        vecs[9]  = '{4'b0001, 1'b1, 16'h0040, 32'h0,        16'h0044, 16'h0044, 1'b0, 16'h0040, 32'h11110000, 1'b1, 32'd2};
        vecs[10] = '{4'b1000, 1'b0, 16'h0000, 32'h22220000, 16'h0044, 16'h0040, 1'b1, 16'h0040, 32'h22220000, 1'b1, 32'd2};
        vecs[11] = '{4'b0100, 1'b0, 16'h0000, 32'h0,        16'h0044, 16'h0044, 1'b0, 16'h0041, 32'h22220000, 1'b1, 32'd2};
        vecs[12] = '{4'b0010, 1'b1, 16'h0099, 32'h0,        16'h0066, 16'h0066, 1'b0, 16'h0041, 32'h22220000, 1'b1, 32'd2};
        vecs[13] = '{4'b0001, 1'b0, 16'h0099, 32'h0,        16'h0066, 16'h0066, 1'b0, 16'h0041, 32'h22220000, 1'b1, 32'd3};
        vecs[14] = '{4'b0000, 1'b1, 16'h0099, 32'h0,        16'h0077, 16'h0077, 1'b0, 16'h0041, 32'h22220000, 1'b1, 32'd3};

        reset = 1'b1;
        {phf, phe, phm, phw} = 4'b0000;
        branch_taken = 1'b0; branch_target = '0; mem_rdata = '0; dmem_addr = '0; irq = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ic", ic, 32'h0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_icnt", icnt, 32'd0);
        chk("rst_err", phase_err, 1'b0);
        chk("rst_ack", irq_ack, 1'b0);
        chk("rst_epc", epc, 16'h0000);
        chk("rst_wrap_pc", w_pc, 16'hFFFF);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].ph, vecs[i].bt, vecs[i].tgt, vecs[i].rdata, vecs[i].dmem, 1'b0);
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_fetch", i), mem_fetch, vecs[i].e_fetch);
            tick();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_ic", i), ic, vecs[i].e_ic);
            chk($sformatf("v%0d_valid", i), inst_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_icnt", i), icnt, vecs[i].e_icnt);
            chk($sformatf("v%0d_err", i), phase_err, 1'b0);
        end

        // phe and phw together: only the error flag may move
        drive(4'b0101, 1'b1, 16'h0123, 32'h0, 16'h0000, 1'b0);
        tick();
        chk("perr_set", phase_err, 1'b1);
        chk("perr_pc", pc, 16'h0041);
        chk("perr_icnt", icnt, 32'd3);
        drive(4'b1000, 1'b0, 16'h0000, 32'h33330000, 16'h0000, 1'b0);
        tick();
        chk("perr_sticky1", phase_err, 1'b1);
        chk("perr_fetch_ok", ic, 32'h33330000);
        drive(4'b0100, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b0);
        tick();
        chk("perr_sticky2", phase_err, 1'b1);
        chk("perr_exec_ok", pc, 16'h0042);

        // reset asserted in the middle of phm
        drive(4'b0010, 1'b0, 16'h0000, 32'h0, 16'h0100, 1'b0);
        reset = 1'b1;
        tick();
        chk("mrst_pc", pc, 16'h0000);
        chk("mrst_ic", ic, 32'h0);
        chk("mrst_icnt", icnt, 32'd0);
        chk("mrst_valid", inst_valid, 1'b0);
        chk("mrst_err", phase_err, 1'b0);
        chk("mrst_wrap_pc", w_pc, 16'hFFFF);

        // wrap instance: FFFF + 1 = 0000
        drive(4'b1000, 1'b0, 16'h0000, 32'h44440000, 16'h0000, 1'b0);
        reset = 1'b0;
        chk("wrap_fetch_addr", w_mem_addr, 16'hFFFF);
        tick();
        drive(4'b0100, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b0);
        tick();
        chk("wrap_pc", w_pc, 16'h0000);
        drive(4'b0010, 1'b0, 16'h0000, 32'h0, 16'h1234, 1'b0);
        chk("wrap_phm_addr", w_mem_addr, 16'h1234);
        tick();
        drive(4'b0001, 1'b1, 16'h0004, 32'h0, 16'h0000, 1'b0);
        tick();
        chk("irqprep_pc", pc, 16'h0004);

        // interrupt entry at pc=0005 with no branch; irq in phe must be ignored
        drive(4'b1000, 1'b0, 16'h0000, 32'h55550000, 16'h0000, 1'b0);
        tick();
        drive(4'b0100, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b1);
        tick();
        chk("irq_phe_pc", pc, 16'h0005);
        chk("irq_phe_ack", irq_ack, 1'b0);
        drive(4'b0010, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b0);
        tick();
        drive(4'b0001, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b1);
        tick();
`ifdef FETCHU_IRQ_EN
        chk("irq_pc", pc, 16'h0002);
        chk("irq_epc", epc, 16'h0005);
        chk("irq_ack1", irq_ack, 1'b1);
`else
        chk("irq_pc", pc, 16'h0005);
        chk("irq_epc", epc, 16'h0000);
        chk("irq_ack1", irq_ack, 1'b0);
`endif
        chk("irq_icnt", icnt, 32'd2);
        drive(4'b0000, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b0);
        tick();
        chk("irq_ack2", irq_ack, 1'b0);

`ifdef FETCHU_IRQ_EN
        // irq together with a taken branch: return PC is the branch destination
        drive(4'b0001, 1'b1, 16'h0030, 32'h0, 16'h0000, 1'b1);
        tick();
        chk("irqbr_pc", pc, 16'h0002);
        chk("irqbr_epc", epc, 16'h0030);
        chk("irqbr_ack", irq_ack, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
